// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : Integer register file feeding the ALU. Two combinational read
//            ports, one synchronous write port, x0 hardwired to zero, and a
//            write-first bypass so a value being written this cycle is
//            already visible on the read ports.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset, clears every entry
//   rs1_addr  in   read port 1 index
//   rs2_addr  in   read port 2 index
//   rs1_data  out  read port 1 data (ALU first_operand)
//   rs2_data  out  read port 2 data (ALU second_operand / immediate mux)
//   reg_write in   write enable from the writeback path
//   rd_addr   in   write index
//   rd_data   in   write data (ALU result or load data)
//   dbg_addr  in   debug read index   (only with REGFILE_DBG_PORT_EN)
//   dbg_data  out  debug read data    (only with REGFILE_DBG_PORT_EN)
// Build option
//   REGFILE_DBG_PORT_EN : adds the dbg_addr/dbg_data third read port, which
//                         follows the same precedence rules as rs1/rs2.
// ============================================================================
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
`ifdef REGFILE_DBG_PORT_EN
  ,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
`endif
);

  // --------------------------------------------------------------------------
  // Configuration check (simulation / elaboration only)
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  generate
    if (NUM_REGS != 2**ADDR_WIDTH) begin : g_cfg_check
      $error("register_file: NUM_REGS (%0d) must equal 2**ADDR_WIDTH (%0d)",
             NUM_REGS, 2**ADDR_WIDTH);
    end
  endgenerate
`endif

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // A write only lands outside reset and never to x0. Entry 0 therefore
  // stays at its reset value of zero for ever.
  logic w_wr_en;
  assign w_wr_en = rst_n && reg_write && (rd_addr != '0);

  // Bypass is only meaningful when a write will actually commit at the
  // coming edge; during reset the pending write is discarded, so reads must
  // show the stored contents instead.
  logic w_bypass_en;
  assign w_bypass_en = rst_n && reg_write;

  always_comb begin
    regs_d = regs_q;
    if (w_wr_en) begin
      regs_d[rd_addr] = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: x0 first, then write-first bypass, then stored entry.
  // The x0 test sits above the bypass so a dropped write to x0 never leaks
  // onto a read port.
  // --------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] read_mux(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  bypass_en,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data
  );
    logic [DATA_WIDTH-1:0] result;
    if (addr == '0) begin
      result = '0;
    end else if (bypass_en && (wr_addr == addr)) begin
      result = wr_data;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  always_comb begin
    rs1_data = read_mux(rs1_addr, regs_q[rs1_addr], w_bypass_en, rd_addr, rd_data);
  end

  always_comb begin
    rs2_data = read_mux(rs2_addr, regs_q[rs2_addr], w_bypass_en, rd_addr, rd_data);
  end

`ifdef REGFILE_DBG_PORT_EN
  always_comb begin
    dbg_data = read_mux(dbg_addr, regs_q[dbg_addr], w_bypass_en, rd_addr, rd_data);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Self-checking bench for register_file. Directed vector table
//            plus an all-entries sweep and a randomised phase against a
//            reference model; expectations go through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          reg_write;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
`ifdef REGFILE_DBG_PORT_EN
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
`endif

  register_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .reg_write(reg_write),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`ifdef REGFILE_DBG_PORT_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = one clock cycle of stimulus and the read data required
  // before that cycle's closing edge.
  typedef struct {
    logic          rst_n;
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] wdata;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  typedef struct {
    int            tag;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input int tag,
                       input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, tag, act, req);
    end
  endtask

  // Drive at the falling edge, record the expectation, sample 2 time units
  // later (well before the rising edge that commits the write).
  task automatic apply(input int tag, input logic rn, input logic we,
                       input logic [AW-1:0] rd, input logic [DW-1:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    @(negedge clk);
    rst_n = rn; reg_write = we; rd_addr = rd; rd_data = wd;
    rs1_addr = a1; rs2_addr = a2;
    e.tag = tag; e.e1 = e1; e.e2 = e2;
    sb_q.push_back(e);
    #2;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard[%0d]: queue empty, expected 1 entry", tag);
    end else begin
      e = sb_q.pop_front();
      check("rs1_data", e.tag, rs1_data, e.e1);
      check("rs2_data", e.tag, rs2_data, e.e2);
    end
  endtask

  vec_t          vecs[18];
  logic [DW-1:0] mdl [NR];

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = '0; rs2_addr = '0;
`ifdef REGFILE_DBG_PORT_EN
    dbg_addr = '0;
`endif

    //            rst  we  rd   wdata          ra1 ra2  exp1           exp2
    vecs[0]  = '{1'b0,1'b1,5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'h0,         32'h0};
    vecs[1]  = '{1'b1,1'b0,5'd0, 32'h0,        5'd5, 5'd31,32'h0,         32'h0};
    vecs[2]  = '{1'b1,1'b1,5'd7, 32'h00001234, 5'd7, 5'd7, 32'h00001234,  32'h00001234};
    vecs[3]  = '{1'b1,1'b0,5'd0, 32'h0,        5'd7, 5'd7, 32'h00001234,  32'h00001234};
    vecs[4]  = '{1'b1,1'b1,5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0,         32'h00001234};
    vecs[5]  = '{1'b1,1'b0,5'd0, 32'h0,        5'd0, 5'd0, 32'h0,         32'h0};
    vecs[6]  = '{1'b1,1'b1,5'd3, 32'd10,       5'd3, 5'd0, 32'd10,        32'h0};
    vecs[7]  = '{1'b1,1'b1,5'd3, 32'd25,       5'd4, 5'd3, 32'h0,         32'd25};
    vecs[8]  = '{1'b1,1'b0,5'd0, 32'h0,        5'd3, 5'd4, 32'd25,        32'h0};
    vecs[9]  = '{1'b1,1'b1,5'd9, 32'h0000000A, 5'd9, 5'd3, 32'h0000000A,  32'd25};
    vecs[10] = '{1'b1,1'b1,5'd9, 32'h0000000B, 5'd9, 5'd9, 32'h0000000B,  32'h0000000B};
    vecs[11] = '{1'b1,1'b0,5'd0, 32'h0,        5'd9, 5'd7, 32'h0000000B,  32'h00001234};
    vecs[12] = '{1'b1,1'b1,5'd31,32'h80000000, 5'd31,5'd30,32'h80000000,  32'h0};
    vecs[13] = '{1'b1,1'b0,5'd0, 32'h0,        5'd31,5'd31,32'h80000000,  32'h80000000};
    vecs[14] = '{1'b0,1'b1,5'd31,32'h00000001, 5'd31,5'd7, 32'h80000000,  32'h00001234};
    vecs[15] = '{1'b1,1'b0,5'd0, 32'h0,        5'd31,5'd7, 32'h0,         32'h0};
    vecs[16] = '{1'b1,1'b1,5'd7, 32'h00005555, 5'd7, 5'd3, 32'h00005555,  32'h0};
    vecs[17] = '{1'b1,1'b0,5'd0, 32'h0,        5'd7, 5'd31,32'h00005555,  32'h0};

    // Two plain reset edges so every entry is defined before any check.
    repeat (2) @(posedge clk);

    // Reset clear with a discarded write, then release.
    for (int i = 0; i < 2; i++) begin
      apply(i, vecs[i].rst_n, vecs[i].we, vecs[i].rd, vecs[i].wdata,
            vecs[i].ra1, vecs[i].ra2, vecs[i].exp1, vecs[i].exp2);
    end

    // Every entry reads zero after reset.
    for (int i = 0; i < NR / 2; i++) begin
      apply(100 + i, 1'b1, 1'b0, '0, '0, AW'(i), AW'(i + NR / 2), '0, '0);
    end

    // Remaining directed rows.
    for (int i = 2; i < 18; i++) begin
      apply(i, vecs[i].rst_n, vecs[i].we, vecs[i].rd, vecs[i].wdata,
            vecs[i].ra1, vecs[i].ra2, vecs[i].exp1, vecs[i].exp2);
    end

`ifdef REGFILE_DBG_PORT_EN
    // Debug port: bypass on the write cycle, stored value afterwards, x0.
    @(negedge clk);
    rst_n = 1'b1; reg_write = 1'b1; rd_addr = 5'd12; rd_data = 32'd99;
    dbg_addr = 5'd12;
    #2 check("dbg_bypass", 200, dbg_data, 32'd99);
    @(negedge clk);
    reg_write = 1'b0;
    #2 check("dbg_stored", 201, dbg_data, 32'd99);
    dbg_addr = 5'd0;
    #1 check("dbg_x0", 202, dbg_data, 32'h0);
`endif

    // Randomised phase against a reference model. Start from a known state.
    apply(300, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    for (int n = 0; n < 200; n++) begin
      logic          rn, we;
      logic [AW-1:0] rd, a1, a2;
      logic [DW-1:0] wd, e1, e2;
      rn = ($urandom_range(0, 29) != 0);
      we = $urandom_range(0, 1) == 1;
      rd = AW'($urandom_range(0, NR - 1));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NR - 1));
      a2 = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NR - 1));
      e1 = (a1 == 0) ? '0 : (rn && we && rd == a1) ? wd : mdl[a1];
      e2 = (a2 == 0) ? '0 : (rn && we && rd == a2) ? wd : mdl[a2];
      apply(400 + n, rn, we, rd, wd, a1, a2, e1, e2);
      if (!rn) begin
        for (int i = 0; i < NR; i++) mdl[i] = '0;
      end else if (we && rd != 0) begin
        mdl[rd] = wd;
      end
    end

    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- Integer register file directly upstream of the ALU; supplies first_operand (rs1) and second_operand (rs2) each cycle.
- 2 combinational read ports, 1 synchronous write port, x0 hardwired to zero.
- Write-first bypass: a value written at the cycle-ending edge is already visible on the read ports in the same cycle.
- Write port is driven by the writeback path (ALU result or load data).

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- ADDR_WIDTH, 5, width of register index fields
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- rs1_addr  input  ADDR_WIDTH  read port 1 index
- rs2_addr  input  ADDR_WIDTH  read port 2 index
- rs1_data  output  DATA_WIDTH  read port 1 data, feeds ALU first_operand
- rs2_data  output  DATA_WIDTH  read port 2 data, feeds ALU second_operand or immediate mux
- reg_write  input  1  write enable
- rd_addr  input  ADDR_WIDTH  write index
- rd_data  input  DATA_WIDTH  write data
- dbg_addr  input  ADDR_WIDTH  debug read index (only with REGFILE_DBG_PORT_EN)
- dbg_data  output  DATA_WIDTH  debug read data (only with REGFILE_DBG_PORT_EN)

Behaviour:
- Reset and clock:
  - One clock domain.
  - Reset is synchronous and active-low: at a rising clk edge with rst_n=0, all NUM_REGS entries are cleared to 0.
  - A write presented in the same cycle as reset is discarded; reset wins.
- Storage and writes:
  - Array of NUM_REGS x DATA_WIDTH flops.
  - Write occurs at a rising edge when rst_n=1, reg_write=1 and rd_addr!=0.
  - Writes to index 0 are silently dropped; entry 0 stays 0 forever.
- Reads:
  - Combinational, zero latency; rs1_data and rs2_data follow the address within the same cycle.
  - Port precedence for rsN_data, highest first:
    1. rsN_addr==0 -> 0.
    2. rst_n=1, reg_write=1 and rd_addr==rsN_addr -> rd_data (bypass).
    3. Otherwise -> stored entry.
  - Bypass is disabled while rst_n=0: reads return stored contents, and no write is pending.
  - Both ports may address the same register; both return identical data, bypass included.
- Outputs after reset: all reads return 0 until the first write.
- No read-side state and no handshake; the block never stalls.
- Boundaries:
  - rd_addr=NUM_REGS-1 (31) is writable like any other entry.
  - Back-to-back writes to the same index: the last write is visible at the next edge.
  - A write and a read to the same index in one cycle: the read returns the new data (write-first).
  - Reset deasserted mid-program: contents stay 0 until rewritten.
- No X may propagate from unwritten entries; every entry is defined after the first reset edge.
- Simulation check:
  - Flag NUM_REGS != 2**ADDR_WIDTH at elaboration.
  - Excluded from synthesis.

Optional Feature:
- Macro: REGFILE_DBG_PORT_EN.
- Defined:
  - Adds the dbg_addr/dbg_data third read port for the testbench and debug monitor.
  - Combinational, same precedence rules as rs1/rs2, bypass included.
- Undefined:
  - Ports dbg_addr/dbg_data do not exist.
  - No extra read mux is built.
  - All other behaviour is identical.

Test Plan:
- Reset clear: hold rst_n=0 one edge with reg_write=1, rd_addr=5, rd_data=32'hDEADBEEF; release; read rs1_addr=5 -> rs1_data=0, and all 32 entries read 0.
- Basic write/read: write x7=32'h0000_1234; next cycle rs1_addr=7, rs2_addr=7 -> both 32'h0000_1234.
- x0 hardwired: write rd_addr=0, rd_data=32'hFFFF_FFFF; same cycle and next, rs1_addr=0 -> 0 (bypass suppressed).
- Bypass: with x3=10 stored, assert reg_write, rd_addr=3, rd_data=25 while rs2_addr=3 -> rs2_data=25 in that cycle; rs1_addr=4 is unaffected.
- Reset mid-operation: after x31=32'h8000_0000, pull rst_n=0 for one edge while writing x31=1 -> x31 reads 0 afterwards; rs1_data shows no bypass of 1 during the reset cycle.
- Debug port (REGFILE_DBG_PORT_EN): write x12=99; dbg_addr=12 -> dbg_data=99; dbg_addr=0 -> 0. Build without the macro also compiles and passes the other tests.
